// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing with a ready-handshaked memory port.
// Optional retired-instruction counter output `instret` is enabled by defining MC_INSTRET_COUNTER_EN.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic [1:0] ALUOp,
    output logic       illegal_instr
`ifdef MC_INSTRET_COUNTER_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned ALUOP_W   = 2;

    localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 7'b1100011;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_R   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_I   = 2'b11;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [OPCODE_W-1:0] op_q;
    logic                op_legal_c;

    // State register; reset low on any edge forces RESET and drops any outstanding request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is captured only while decoding; later IR changes are invisible to the FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q <= '0;
        end else if (state == S_DECODE) begin
            op_q <= Opcode;
        end
    end

    always_comb begin
        op_legal_c = 1'b0;
        case (Opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: op_legal_c = 1'b1;
            default:                          op_legal_c = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = op_legal_c ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (op_q)
                    OP_BEQ:       state_next = S_FETCH;
                    OP_LW, OP_SW: state_next = S_MEM;
                    default:      state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_FETCH;
            default:  state_next = S_RESET;
        endcase
    end

    // Moore outputs from state/op_q; only the fetch IR/PC load follows mem_ready directly.
    always_comb begin
        mem_req       = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        ALUSrc        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        Branch        = 1'b0;
        ALUOp         = ALU_ADD;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R:   ALUOp = ALU_R;
                    OP_I:   ALUOp = ALU_I;
                    OP_BEQ: ALUOp = ALU_BR;
                    default: ALUOp = ALU_ADD;
                endcase
                ALUSrc = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_I);
                Branch = (op_q == OP_BEQ);
            end
            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (op_q == OP_LW);
            end
            S_TRAP: illegal_instr = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_INSTRET_COUNTER_EN
    localparam int unsigned INSTRET_W = 32;

    logic retire_c;

    // A retirement is any return to FETCH except the one out of TRAP.
    always_comb begin
        retire_c = (state_next == S_FETCH) &&
                   ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret <= '0;
        end else if (retire_c) begin
            instret <= instret + INSTRET_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model expands each instruction into expected per-cycle outputs.
// Compile with MC_INSTRET_COUNTER_EN defined to also check the retired-instruction counter.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] Opcode;
    logic       mem_ready;
    logic       mem_req, IorD, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite;
    logic       MemRead, MemWrite, Branch, illegal_instr;
    logic [1:0] ALUOp;
`ifdef MC_INSTRET_COUNTER_EN
    logic [31:0] instret;
`endif

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .Opcode       (Opcode),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .IorD         (IorD),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .ALUSrc       (ALUSrc),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Branch       (Branch),
        .ALUOp        (ALUOp),
        .illegal_instr(illegal_instr)
`ifdef MC_INSTRET_COUNTER_EN
        ,
        .instret      (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL7F = 5, K_ILLRND = 6;

    typedef struct {
        bit          chk;
        logic [12:0] sig;
        logic [31:0] ir;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ret_cnt = 32'd0;
    logic [12:0] act;

    assign act = {mem_req, IorD, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
                  MemRead, MemWrite, Branch, ALUOp, illegal_instr};

    // Output vector in the same bit order as 'act'.
    function automatic logic [12:0] o(input bit mreq, input bit iord, input bit irw, input bit pcw,
                                      input bit asrc, input bit m2r, input bit rw, input bit mr,
                                      input bit mw, input bit br, input logic [1:0] aop, input bit ill);
        return {mreq, iord, irw, pcw, asrc, m2r, rw, mr, mw, br, aop, ill};
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rand_illegal();
        logic [6:0] v;
        v = 7'($urandom);
        while (v == 7'b0110011 || v == 7'b0010011 || v == 7'b0000011 ||
               v == 7'b0100011 || v == 7'b1100011)
            v = 7'($urandom);
        return v;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be during that cycle.
    task automatic step(input bit r, input logic [6:0] op, input bit rdy,
                        input logic [12:0] sig, input bit chk, input string tag);
        exp_t e;
        reset     = r;
        Opcode    = op;
        mem_ready = rdy;
        e.chk = chk;
        e.sig = sig;
        e.ir  = ret_cnt;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle sequence; fw/mw are wait cycles in FETCH/MEM.
    task automatic run_instr(input int kind, input int fw, input int mw, input bit rst_mem);
        logic [6:0]  opc;
        logic [1:0]  aop;
        bit          asrc, is_lw, is_sw, is_beq, is_ill;
        logic [12:0] f, m;
        aop = 2'b00; asrc = 0;
        is_lw = (kind == K_LW); is_sw = (kind == K_SW); is_beq = (kind == K_BEQ);
        is_ill = (kind == K_ILL7F) || (kind == K_ILLRND);
        case (kind)
            K_R:     begin opc = 7'b0110011; aop = 2'b10; end
            K_I:     begin opc = 7'b0010011; aop = 2'b11; asrc = 1; end
            K_LW:    begin opc = 7'b0000011; asrc = 1; end
            K_SW:    begin opc = 7'b0100011; asrc = 1; end
            K_BEQ:   begin opc = 7'b1100011; aop = 2'b01; end
            K_ILL7F: opc = 7'b1111111;
            default: opc = rand_illegal();
        endcase
        f = o(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        for (int i = 0; i < fw; i++) step(1, junk(), 0, f, 1, "fetch_wait");
        step(1, junk(), 1, o(1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 0), 1, "fetch");
        step(1, opc, rnd(), 13'd0, 1, "decode");
        if (is_ill) begin
            step(1, junk(), rnd(), o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), 1, "trap");
            return;
        end
        step(1, junk(), rnd(), o(0, 0, 0, 0, asrc, 0, 0, 0, 0, is_beq, aop, 0), 1, "exec");
        if (is_beq) begin
            ret_cnt = ret_cnt + 32'd1;
            return;
        end
        if (is_lw || is_sw) begin
            m = o(1, 1, 0, 0, 0, 0, 0, is_lw, is_sw, 0, 2'b00, 0);
            for (int i = 0; i < mw; i++) step(1, junk(), 0, m, 1, "mem_wait");
            if (rst_mem) begin
                step(0, junk(), 0, m, 1, "mem_reset_edge");
                ret_cnt = 32'd0;
                step(1, junk(), rnd(), 13'd0, 1, "after_reset");
                return;
            end
            step(1, junk(), 1, m, 1, "mem");
            if (is_sw) begin
                ret_cnt = ret_cnt + 32'd1;
                return;
            end
        end
        step(1, junk(), rnd(), o(0, 0, 0, 0, 0, is_lw, 1, 0, 0, 0, 2'b00, 0), 1, "wb");
        ret_cnt = ret_cnt + 32'd1;
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (act !== e.sig) begin
                        errors++;
                        $display("FAIL %s t=%0t: outputs got %b expected %b", e.tag, $time, act, e.sig);
                    end
`ifdef MC_INSTRET_COUNTER_EN
                    checks++;
                    if (instret !== e.ir) begin
                        errors++;
                        $display("FAIL %s_instret t=%0t: got %0d expected %0d", e.tag, $time, instret, e.ir);
                    end
`endif
                end
            end
        end
    end

    initial begin
        int kind, fw, mw;
        bit rm;
        reset = 1'b0; Opcode = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(0, junk(), rnd(), 13'd0, 0, "reset_first");
        step(0, junk(), rnd(), 13'd0, 1, "reset_low");
        step(0, junk(), rnd(), 13'd0, 1, "reset_low");
        step(1, junk(), rnd(), 13'd0, 1, "reset_state");

        run_instr(K_R, 0, 0, 0);
        run_instr(K_LW, 0, 2, 0);
        run_instr(K_SW, 0, 0, 0);
        run_instr(K_BEQ, 0, 0, 0);
        run_instr(K_ILL7F, 0, 0, 0);
        run_instr(K_SW, 1, 1, 1);
        run_instr(K_I, 2, 0, 0);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 6);
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            mw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            rm = (kind == K_SW) && ($urandom_range(0, 9) == 0);
            run_instr(kind, fw, mw, rm);
        end

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
